// File: rtl/con_eval_unit.sv
// rtl/con_eval_unit.sv - branch condition (CON) evaluation unit with take/valid handshake
// Optional statistics counters are compiled in with `define CON_STATS_EN.
module con_eval_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  con_in,
    input  logic [2:0]            c2,
    input  logic [DATA_WIDTH-1:0] bus_mux_out,
    input  logic                  con_take,
    output logic                  con_out,
    output logic                  con_valid,
    output logic                  busy
`ifdef CON_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  eval_cnt,
    output logic [CNT_WIDTH-1:0]  taken_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    generate
        if (DATA_WIDTH < 2 || DATA_WIDTH > 64 || CNT_WIDTH < 1) begin : g_bad_param
            $error("con_eval_unit: illegal DATA_WIDTH or CNT_WIDTH");
        end
    endgenerate

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic [2:0]              c2_q;
    logic                    con_out_q;
    logic                    con_valid_q;
    logic                    busy_q;
    logic                    cond_d;
    logic                    opnd_zero;
    logic                    opnd_sign;

    assign opnd_zero = (opnd_q == '0);
    assign opnd_sign = opnd_q[DATA_WIDTH-1];

    always_comb begin
        cond_d = 1'b0;
        case (c2_q)
            3'd0: cond_d = opnd_zero;
            3'd1: cond_d = !opnd_zero;
            3'd2: cond_d = !opnd_sign;
            3'd3: cond_d = opnd_sign;
            3'd4: cond_d = !opnd_sign && !opnd_zero;
            3'd5: cond_d = opnd_sign || opnd_zero;
            3'd6: cond_d = 1'b1;
            default: cond_d = 1'b0;
        endcase
    end

`ifdef CON_STATS_EN
    logic [CNT_WIDTH-1:0] eval_cnt_q;
    logic [CNT_WIDTH-1:0] taken_cnt_q;
    logic [CNT_WIDTH-1:0] eval_cnt_d;
    logic [CNT_WIDTH-1:0] taken_cnt_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (state_q == ST_EVAL) begin
            if (eval_cnt_q != '1) begin
                eval_cnt_d = eval_cnt_q + 1'b1;
            end
            if (cond_d && taken_cnt_q != '1) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

    // busy_q mirrors "next state is EVAL" so it is a registered copy of the state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            opnd_q      <= '0;
            c2_q        <= 3'd0;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (con_in) begin
                        opnd_q  <= bus_mux_out;
                        c2_q    <= c2;
                        state_q <= ST_EVAL;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    con_out_q   <= cond_d;
                    con_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                    busy_q      <= 1'b0;
                end
                ST_HOLD: begin
                    if (con_in) begin
                        opnd_q      <= bus_mux_out;
                        c2_q        <= c2;
                        con_valid_q <= 1'b0;
                        state_q     <= ST_EVAL;
                        busy_q      <= 1'b1;
                    end else if (con_take) begin
                        con_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    con_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign con_out   = con_out_q;
    assign con_valid = con_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_con_eval_unit.sv
// tb/tb_con_eval_unit.sv - directed-vector bench for con_eval_unit
module tb_con_eval_unit;

`ifdef CON_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        con_in = 1'b0;
    logic [2:0]  c2 = 3'd0;
    logic [31:0] bus_mux_out = 32'h0;
    logic        con_take = 1'b0;
    logic        con_out;
    logic        con_valid;
    logic        busy;
`ifdef CON_STATS_EN
    logic [CW-1:0] eval_cnt;
    logic [CW-1:0] taken_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    con_eval_unit #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .clr        (clr),
        .con_in     (con_in),
        .c2         (c2),
        .bus_mux_out(bus_mux_out),
        .con_take   (con_take),
        .con_out    (con_out),
        .con_valid  (con_valid),
        .busy       (busy)
`ifdef CON_STATS_EN
        ,
        .eval_cnt   (eval_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load, evaluate, check result, then consume it back to IDLE.
    task automatic run_eval(input string tag, input logic [2:0] cc, input logic [31:0] bus,
                            input logic exp);
        con_in = 1'b1; c2 = cc; bus_mux_out = bus;
        step();
        con_in = 1'b0; bus_mux_out = 32'hDEAD_BEEF;
        chk({tag, "_busy"}, busy, 1'b1);
        step();
        chk({tag, "_valid"}, con_valid, 1'b1);
        chk({tag, "_out"}, con_out, exp);
        con_take = 1'b1;
        step();
        con_take = 1'b0;
        chk({tag, "_taken_valid"}, con_valid, 1'b0);
        chk({tag, "_taken_out"}, con_out, exp);
    endtask

    initial begin
        #2;
        chk("rst_out", con_out, 1'b0);
        chk("rst_valid", con_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step();
        clr = 1'b0;
        step();
        step();
        chk("post_rst_valid", con_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        // con_take in IDLE has no effect
        con_take = 1'b1;
        step();
        con_take = 1'b0;
        chk("idle_take_valid", con_valid, 1'b0);
        chk("idle_take_busy", busy, 1'b0);

        run_eval("zero_0", 3'd0, 32'h0000_0000, 1'b1);
        run_eval("zero_4", 3'd0, 32'h0000_0004, 1'b0);
        run_eval("nz_4", 3'd1, 32'h0000_0004, 1'b1);
        run_eval("ge_neg", 3'd2, 32'h8000_0000, 1'b0);
        run_eval("lt_neg", 3'd3, 32'h8000_0000, 1'b1);
        run_eval("gt_zero", 3'd4, 32'h0000_0000, 1'b0);
        run_eval("gt_pos", 3'd4, 32'h0000_0005, 1'b1);
        run_eval("le_zero", 3'd5, 32'h0000_0000, 1'b1);
        run_eval("le_pos", 3'd5, 32'h7FFF_FFFF, 1'b0);
        run_eval("always", 3'd6, 32'h1234_5678, 1'b1);
        run_eval("never", 3'd7, 32'h0000_0000, 1'b0);

        // con_in during EVAL is ignored: operand 0 with c2=0 must give 1
        con_in = 1'b1; c2 = 3'd0; bus_mux_out = 32'h0;
        step();
        c2 = 3'd7; bus_mux_out = 32'hFFFF_FFFF;
        step();
        con_in = 1'b0;
        chk("eval_ign_valid", con_valid, 1'b1);
        chk("eval_ign_out", con_out, 1'b1);

        // HOLD + con_in without take: discard, re-evaluate (c2=7 -> 0)
        con_in = 1'b1; c2 = 3'd7; bus_mux_out = 32'h0;
        step();
        con_in = 1'b0;
        chk("hold_reload_valid", con_valid, 1'b0);
        chk("hold_reload_busy", busy, 1'b1);
        step();
        chk("hold_reload_out", con_out, 1'b0);
        chk("hold_reload_valid2", con_valid, 1'b1);

        // HOLD + take + con_in together, c2=6
        con_in = 1'b1; con_take = 1'b1; c2 = 3'd6; bus_mux_out = 32'h0;
        step();
        con_in = 1'b0; con_take = 1'b0;
        chk("simul_busy", busy, 1'b1);
        chk("simul_valid", con_valid, 1'b0);
        step();
        chk("simul_valid2", con_valid, 1'b1);
        chk("simul_out", con_out, 1'b1);

        // Reset while busy with con_out=1: outputs clear without a clock edge
        con_in = 1'b1; c2 = 3'd7; bus_mux_out = 32'h0;
        step();
        con_in = 1'b0;
        chk("pre_clr_busy", busy, 1'b1);
        chk("pre_clr_out", con_out, 1'b1);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_out", con_out, 1'b0);
        chk("clr_valid", con_valid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        step();
        clr = 1'b0;
        step();
        chk("clr_after_busy", busy, 1'b0);
        chk("clr_after_valid", con_valid, 1'b0);

`ifdef CON_STATS_EN
        chk("stats_rst_eval", eval_cnt, 0);
        chk("stats_rst_taken", taken_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            run_eval("stats_ev", 3'd6, 32'h0, 1'b1);
        end
        chk("stats_eval_sat", eval_cnt, 3);
        chk("stats_taken_sat", taken_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/con_eval_unit.md
CON_EVAL_UNIT -- requirements
Module: con_eval_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the evaluated bus operand (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 clr  input  1  asynchronous active-high reset.
REQ-006 con_in  input  1  load strobe; captures bus_mux_out and c2 in the same cycle.
REQ-007 c2  input  3  condition code from the IR C2 field.
REQ-008 bus_mux_out  input  DATA_WIDTH  operand from the datapath bus.
REQ-009 con_take  input  1  consume strobe from PC-update logic.
REQ-010 con_out  output  1  registered CON flip-flop; 1 means branch taken.
REQ-011 con_valid  output  1  con_out holds an unconsumed result.
REQ-012 busy  output  1  evaluation in progress (state EVAL).
REQ-013 eval_cnt, taken_cnt  output  CNT_WIDTH each  present only under CON_STATS_EN.

Function
REQ-014 The FSM SHALL have three states: IDLE, EVAL and HOLD; it SHALL reset to IDLE.
REQ-015 In IDLE or HOLD, con_in=1 SHALL register the operand and c2 and move the FSM to EVAL on the next edge.
REQ-016 In EVAL, the block SHALL compute the condition from the registered operand, write con_out, set con_valid=1 and move to HOLD on one edge (con_in-to-con_valid latency = 2 cycles).
REQ-017 Condition encoding SHALL be: 0 zero; 1 nonzero; 2 ge (MSB=0); 3 lt (MSB=1); 4 gt (MSB=0 and nonzero); 5 le (MSB=1 or zero); 6 always 1; 7 never 0.
REQ-018 Sign SHALL be taken from bit DATA_WIDTH-1; zero means every bit is 0.
REQ-019 In HOLD, con_take=1 with con_in=0 SHALL clear con_valid and return the FSM to IDLE; con_out SHALL keep its value.
REQ-020 In HOLD, con_take=1 with con_in=1 SHALL consume the current result and capture the new operand, moving to EVAL with con_valid=0.
REQ-021 In HOLD, con_in=1 with con_take=0 SHALL discard the unconsumed result, clear con_valid and move to EVAL.
REQ-022 In EVAL, con_in SHALL be ignored; the captured operand SHALL NOT change.
REQ-023 con_take SHALL be ignored in IDLE and EVAL.
REQ-024 busy SHALL be 1 exactly when the state is EVAL.
REQ-025 Asserting clr at any point, including during EVAL, SHALL abort the evaluation without writing con_out.

Reset
REQ-026 On clr the block SHALL set: state=IDLE, con_out=0, con_valid=0, busy=0, captured operand=0, captured c2=0, and both counters=0.
REQ-027 The outputs SHALL hold their reset values from the first edge after clr is deasserted until a con_in is accepted.

Configuration
REQ-028 Macro CON_STATS_EN SHALL compile in the eval_cnt and taken_cnt ports and their counters.
REQ-029 With CON_STATS_EN defined, eval_cnt SHALL increment on each EVAL-to-HOLD transition.
REQ-030 With CON_STATS_EN defined, taken_cnt SHALL increment on each such transition where the result is 1.
REQ-031 With CON_STATS_EN defined, both counters SHALL saturate at all-ones.
REQ-032 Without CON_STATS_EN, the statistics ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Case zero: con_in with c2=0 and bus=0x00000000 -> two cycles later con_valid=1 and con_out=1; repeat with bus=0x00000004 -> con_out=0.
REQ-034 Case sign: c2=3 with bus=0x80000000 -> con_out=1; c2=4 with bus=0x00000000 -> con_out=0; c2=5 with bus=0x00000000 -> con_out=1.
REQ-035 Case handshake: result in HOLD, con_take=1 -> next cycle con_valid=0, state IDLE, con_out unchanged.
REQ-036 Case simultaneous events: in HOLD, con_take=1 and con_in=1 with c2=6 -> busy=1 next cycle, then con_valid=1 and con_out=1.
REQ-037 Case reset mid-operation: clr pulsed while busy=1, with prior con_out=1 -> con_out=0, con_valid=0, busy=0 immediately, without waiting for a clock edge.
REQ-038 Case statistics (CON_STATS_EN, CNT_WIDTH=2): five evaluations with c2=6 -> eval_cnt=3 and taken_cnt=3 (saturated).
